// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and default constants for the sprite fetch
//               pipeline (sprite geometry, transparent key colour, widths).
// Revision    : 1.0  initial release
// ============================================================================
package sprite_pkg;

  // Default sprite geometry: 30 x 29 = 870 RAM words
  localparam int SPR_W_DEF = 30;
  localparam int SPR_H_DEF = 29;

  // Colour treated as transparent in the sprite image
  localparam logic [23:0] KEY_COLOR_DEF = 24'hFF00FF;

  typedef logic [9:0]  coord_t;
  typedef logic [14:0] addr_t;
  typedef logic [23:0] rgb_t;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : sprite_addr_gen
// Description : Stage 1 of the sprite fetch pipeline. Tests whether the
//               current pixel lies inside the sprite box and registers the
//               sprite RAM address for it. Optional horizontal mirroring is
//               compiled in with macro SPRITE_FLIP_EN.
// Revision    : 1.0  initial release
// ============================================================================
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W     = SPR_W_DEF,
  parameter int SPR_H     = SPR_H_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   pix_valid,
  input  coord_t DrawX,
  input  coord_t DrawY,
  input  coord_t sx,
  input  coord_t sy,
`ifdef SPRITE_FLIP_EN
  input  logic   flip,
`endif
  output addr_t  read_address,
  output logic   s1_valid,
  output logic   s1_inbox
);

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] sx_ext;
  logic [10:0] sy_ext;
  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [10:0] col_raw;
  logic [10:0] row_raw;
  logic        inbox;
  addr_t       col_idx;
  addr_t       addr_next;

  // Box test and address in 11-bit arithmetic so a sprite near x=1023 never wraps to x=0
  always_comb begin
    x_ext   = {1'b0, DrawX};
    y_ext   = {1'b0, DrawY};
    sx_ext  = {1'b0, sx};
    sy_ext  = {1'b0, sy};
    x_end   = sx_ext + 11'(SPR_W);
    y_end   = sy_ext + 11'(SPR_H);
    inbox   = (x_ext >= sx_ext) && (x_ext < x_end) &&
              (y_ext >= sy_ext) && (y_ext < y_end);
    col_raw = x_ext - sx_ext;
    row_raw = y_ext - sy_ext;
    col_idx = addr_t'(col_raw);
`ifdef SPRITE_FLIP_EN
    if (flip) begin
      col_idx = addr_t'(SPR_W - 1) - addr_t'(col_raw);
    end
`endif
    addr_next = addr_t'(BASE_ADDR) + addr_t'(row_raw) * addr_t'(SPR_W) + col_idx;
  end

  // Address only moves on in-box pixels, so it always stays inside the sprite image
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      // Idle address is the first sprite word (0 with the default base)
      read_address <= addr_t'(BASE_ADDR);
      s1_valid     <= 1'b0;
      s1_inbox     <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      s1_inbox <= inbox;
      if (inbox) begin
        read_address <= addr_next;
      end
    end
  end

endmodule : sprite_addr_gen
`default_nettype wire

// File: rtl/sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch
// Description : Three-stage sprite pixel fetch. Holds the per-frame shadow
//               position, drives a synchronous sprite RAM and produces the
//               sprite colour / coverage for each input pixel 3 cycles later.
//               Macro SPRITE_FLIP_EN adds the facing_left mirroring input.
// Revision    : 1.0  initial release
// ============================================================================
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int          SPR_W     = SPR_W_DEF,
  parameter int          SPR_H     = SPR_H_DEF,
  parameter int          BASE_ADDR = 0,
  parameter logic [23:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   frame_start,
  input  logic   pix_valid,
  input  coord_t DrawX,
  input  coord_t DrawY,
  input  coord_t sprite_x,
  input  coord_t sprite_y,
`ifdef SPRITE_FLIP_EN
  input  logic   facing_left,
`endif
  output addr_t  read_address,
  input  rgb_t   ram_data,
  output rgb_t   pixel_rgb,
  output logic   pixel_on,
  output logic   out_valid
);

  coord_t shadow_x;
  coord_t shadow_y;
  logic   s1_valid;
  logic   s1_inbox;
  logic   s2_valid;
  logic   s2_inbox;
  logic   opaque;

`ifdef SPRITE_FLIP_EN
  logic   shadow_flip;

  // Facing direction latched once per frame together with the position
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      shadow_flip <= 1'b0;
    end else if (frame_start) begin
      shadow_flip <= facing_left;
    end
  end
`endif

  // Position latched at vertical blank; a pixel in the same cycle still sees the old one
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      shadow_x <= 10'h3FF;
      shadow_y <= 10'h3FF;
    end else if (frame_start) begin
      shadow_x <= sprite_x;
      shadow_y <= sprite_y;
    end
  end

  sprite_addr_gen #(
    .SPR_W     (SPR_W),
    .SPR_H     (SPR_H),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .sx           (shadow_x),
    .sy           (shadow_y),
`ifdef SPRITE_FLIP_EN
    .flip         (shadow_flip),
`endif
    .read_address (read_address),
    .s1_valid     (s1_valid),
    .s1_inbox     (s1_inbox)
  );

  // Stage 2: carry valid/in-box alongside the RAM access so they meet ram_data
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s2_valid <= 1'b0;
      s2_inbox <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_inbox <= s1_inbox;
    end
  end

  // A covered pixel is drawn unless its RAM word is the transparent key
  always_comb begin
    opaque = s2_valid && s2_inbox && (ram_data != KEY_COLOR);
  end

  // Stage 3: register outputs; colour is forced to black when not drawn
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pixel_rgb <= '0;
      pixel_on  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      pixel_rgb <= opaque ? ram_data : '0;
      pixel_on  <= opaque;
      out_valid <= s2_valid;
    end
  end

endmodule : sprite_fetch
`default_nettype wire

// File: tb/tb_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_fetch
// Description : Self-checking bench for sprite_fetch: directed corner cases
//               plus randomized pixel streams against a behavioural model.
//               Exercises the facing_left path when SPRITE_FLIP_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_fetch;
  import sprite_pkg::*;

  localparam int          W   = 30;
  localparam int          H   = 29;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic   clk = 1'b0;
  logic   reset_n;
  logic   frame_start;
  logic   pix_valid;
  coord_t draw_x;
  coord_t draw_y;
  coord_t sprite_x;
  coord_t sprite_y;
  logic   facing_left;
  addr_t  read_address;
  rgb_t   ram_data;
  rgb_t   pixel_rgb;
  logic   pixel_on;
  logic   out_valid;

  logic [23:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          v;
    bit          on;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];

  // Behavioural model state: latched position/direction and last address
  int msx, msy, mra;
  bit mfl;

  always #5 clk = ~clk;

  // Synchronous sprite RAM: data one cycle after the address
  always @(posedge clk) ram_data <= mem[read_address[9:0]];

  sprite_fetch dut (
    .Clk          (clk),
    .Reset_n      (reset_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (draw_x),
    .DrawY        (draw_y),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
`ifdef SPRITE_FLIP_EN
    .facing_left  (facing_left),
`endif
    .read_address (read_address),
    .ram_data     (ram_data),
    .pixel_rgb    (pixel_rgb),
    .pixel_on     (pixel_on),
    .out_valid    (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance one edge and compare against the model
  task automatic step(input bit rn, input bit fs, input bit pv, input int x, input int y,
                      input int spx, input int spy, input bit fl);
    exp_t e;
    exp_t z;
    int   col;
    int   row;
    bit   inb;
    z.v = 0; z.on = 0; z.rgb = '0;
    reset_n     = rn;
    frame_start = fs;
    pix_valid   = pv;
    draw_x      = coord_t'(x);
    draw_y      = coord_t'(y);
    sprite_x    = coord_t'(spx);
    sprite_y    = coord_t'(spy);
    facing_left = fl;
    if (rn) begin
      inb = (x >= msx) && (x < msx + W) && (y >= msy) && (y < msy + H);
      col = x - msx;
      row = y - msy;
`ifdef SPRITE_FLIP_EN
      if (mfl) col = W - 1 - col;
`endif
      if (inb) mra = row * W + col;
      e.v   = pv;
      e.on  = pv && inb && (mem[mra] != KEY);
      e.rgb = e.on ? mem[mra] : 24'h0;
      q.push_back(e);
      if (fs) begin
        msx = spx;
        msy = spy;
        mfl = fl;
      end
    end else begin
      q.delete();
      mra = 0;
      msx = 1023;
      msy = 1023;
      mfl = 0;
    end
    @(posedge clk);
    #1;
    check("read_address", 32'(read_address), 32'(mra));
    if (!rn) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pixel_on", 32'(pixel_on), 32'd0);
      check("rst_pixel_rgb", 32'(pixel_rgb), 32'd0);
      q.push_back(z);
      q.push_back(z);
    end else if (q.size() == 3) begin
      e = q.pop_front();
      check("out_valid", 32'(out_valid), 32'(e.v));
      check("pixel_on", 32'(pixel_on), 32'(e.on));
      check("pixel_rgb", 32'(pixel_rgb), 32'(e.rgb));
    end
  endtask

  task automatic pix(input int x, input int y, input int spx, input int spy);
    step(1'b1, 1'b0, 1'b1, x, y, spx, spy, 1'b0);
  endtask

  task automatic frame(input int spx, input int spy, input bit fl);
    step(1'b1, 1'b1, 1'b0, 0, 0, spx, spy, fl);
  endtask

  initial begin
    int sx_r, sy_r, x, y;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = (($urandom % 8) == 0) ? KEY : 24'($urandom);
    end
    mem[0] = 24'h123456;
    mem[5] = KEY;
    msx = 1023; msy = 1023; mra = 0; mfl = 0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    // Sprite at (100,200): top-left, bottom-right and just-outside pixels
    frame(100, 200, 1'b0);
    pix(100, 200, 100, 200);
    check("addr_top_left", 32'(read_address), 32'd0);
    pix(129, 228, 100, 200);
    check("addr_bottom_right", 32'(read_address), 32'd869);
    pix(130, 228, 100, 200);
    check("addr_hold_x_edge", 32'(read_address), 32'd869);
    pix(129, 229, 100, 200);
    check("addr_hold_y_edge", 32'(read_address), 32'd869);
    pix(105, 200, 100, 200);
    check("addr_key_word", 32'(read_address), 32'd5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 100, 200, 1'b0);

    // New position without frame_start is ignored until latched
    for (int i = 100; i < 130; i++) pix(i, 210, 300, 200);
    step(1'b1, 1'b1, 1'b1, 110, 210, 300, 200, 1'b0);
    for (int i = 100; i < 130; i += 3) pix(i, 210, 300, 200);
    for (int i = 300; i < 330; i += 3) pix(i, 210, 300, 200);

    // Right-edge sprite and no-wrap case
    frame(620, 200, 1'b0);
    pix(639, 210, 620, 200);
    check("addr_col19", 32'(read_address), 32'd319);
    frame(1000, 200, 1'b0);
    pix(5, 200, 1000, 200);
    check("addr_no_wrap", 32'(read_address), 32'd319);
    pix(1023, 210, 1000, 200);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, 1000, 200, 1'b0);

`ifdef SPRITE_FLIP_EN
    // Mirrored sprite, then reset in the middle of a stream
    frame(100, 200, 1'b1);
    pix(100, 200, 100, 200);
    check("addr_flip", 32'(read_address), 32'd29);
    pix(129, 201, 100, 200);
    pix(110, 205, 100, 200);
    step(1'b0, 1'b0, 1'b1, 100, 200, 100, 200, 1'b0);
`endif

    // Randomized streams with occasional frame starts and resets
    sx_r = 100; sy_r = 200;
    for (int n = 0; n < 1500; n++) begin
      if (($urandom % 200) == 0) begin
        step(1'b0, 1'b0, 1'b1, 0, 0, sx_r, sy_r, 1'b0);
      end else begin
        if (($urandom % 25) == 0) begin
          sx_r = $urandom_range(0, 1023);
          sy_r = $urandom_range(0, 1023);
        end
        if ($urandom % 2) begin
          x = (msx + $urandom_range(0, W + 10) - 5) & 1023;
          y = (msy + $urandom_range(0, H + 10) - 5) & 1023;
        end else begin
          x = $urandom_range(0, 1023);
          y = $urandom_range(0, 1023);
        end
        step(1'b1, ($urandom % 30) == 0, ($urandom % 5) != 0, x, y, sx_r, sy_r,
             1'($urandom % 2));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 0, sx_r, sy_r, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sprite_fetch
`default_nettype wire
